digit_entry: RTL and testbench

- Keypad-side entry block. Turns one-hot decimal key switches plus a raw "enter" pushbutton into an 8-bit binary guess (0-99).
- Operator enters the tens digit then the ones digit, each confirmed by a debounced press; the block then computes tens*10+ones and issues a one-cycle valid strobe.
- Sits between the board switches/button and the game datapath/control input. It is the inverse of the datapath's binary-to-BCD display path, and echoes the entered digits for the seven-segment decoders.

---
 rtl/digit_entry.sv | 167 ++++++++++++++++
 tb/tb_digit_entry.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// digit_entry: two-digit decimal keypad entry. A debounced "enter" press
// captures the tens digit, then the ones digit, and the block emits
// tens*10+ones with a one-cycle valid strobe.
module digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] DIP,
  input  logic       enter,
  input  logic       clear,
  output logic [7:0] datain,
  output logic       valid,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       pending,
  output logic       err
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_TENS = 1'b0,
    S_ONES = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_rise;

  logic             w_key_ok;
  logic [3:0]       w_digit;
  logic [7:0]       w_tens_x10;

  logic [7:0]       r_datain;
  logic             r_valid;
  logic [3:0]       r_digit_tens;
  logic [3:0]       r_digit_ones;
  logic             r_pending;
  logic             r_err;

  logic [7:0]       w_datain_nxt;
  logic             w_valid_nxt;
  logic [3:0]       w_tens_nxt;
  logic [3:0]       w_ones_nxt;
  logic             w_pending_nxt;
  logic             w_err_nxt;

  // Debounced level is about to toggle from 0 to 1: this is the press event.
  assign w_rise = (r_sync2 != r_db) && (r_cnt == LP_CNT_MAX) && !r_db;

  // Two-flop synchroniser for the raw pushbutton.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= enter;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter: level changes only after a full stable run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_rise;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_MAX) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // One-hot key decode; digit is the index of the single set bit.
  always_comb begin
    w_key_ok = ($countones(DIP) == 1);
    w_digit  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (DIP[i]) w_digit = 4'(i);
    end
  end

  assign w_tens_x10 = (8'(r_digit_tens) << 3) + (8'(r_digit_tens) << 1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_TENS;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: clear wins over a same-cycle press.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_TENS;
    end else if (r_press && w_key_ok) begin
      w_state_nxt = (r_state == S_TENS) ? S_ONES : S_TENS;
    end
  end

  // FSM outputs: next values of the registered digits, result and strobes.
  always_comb begin
    w_datain_nxt  = r_datain;
    w_valid_nxt   = 1'b0;
    w_tens_nxt    = r_digit_tens;
    w_ones_nxt    = r_digit_ones;
    w_err_nxt     = 1'b0;
    w_pending_nxt = (w_state_nxt == S_ONES);
    if (clear) begin
      w_tens_nxt = 4'd0;
      w_ones_nxt = 4'd0;
    end else if (r_press) begin
      if (!w_key_ok) begin
        w_err_nxt = 1'b1;
      end else if (r_state == S_TENS) begin
        w_tens_nxt = w_digit;
        w_ones_nxt = 4'd0;
      end else begin
        w_ones_nxt   = w_digit;
        w_datain_nxt = w_tens_x10 + 8'(w_digit);
        w_valid_nxt  = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_datain     <= 8'd0;
      r_valid      <= 1'b0;
      r_digit_tens <= 4'd0;
      r_digit_ones <= 4'd0;
      r_pending    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_datain     <= w_datain_nxt;
      r_valid      <= w_valid_nxt;
      r_digit_tens <= w_tens_nxt;
      r_digit_ones <= w_ones_nxt;
      r_pending    <= w_pending_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign datain     = r_datain;
  assign valid      = r_valid;
  assign digit_tens = r_digit_tens;
  assign digit_ones = r_digit_ones;
  assign pending    = r_pending;
  assign err        = r_err;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: directed scenarios plus randomized entries checked
// against a digit-level reference model of the operator protocol.
module tb_digit_entry;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] DIP = 10'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] datain;
  logic       valid;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic       pending;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  digit_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .DIP(DIP), .enter(enter), .clear(clear),
    .datain(datain), .valid(valid), .digit_tens(digit_tens),
    .digit_ones(digit_ones), .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts pulses, captures the value seen with valid,
  // and counts protocol violations (overlap or 2-cycle-long strobes).
  int         v_cnt = 0;
  int         e_cnt = 0;
  int         vio_cnt = 0;
  logic [7:0] v_data = 8'd0;
  logic       prev_v = 1'b0;
  logic       prev_e = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1) begin v_cnt++; v_data = datain; end
    if (err === 1'b1) e_cnt++;
    if ((valid && err) || (valid && prev_v) || (err && prev_e)) vio_cnt++;
    prev_v = valid;
    prev_e = err;
  end

  // Clean press: hold well past the debounce window, then release.
  task automatic press(input logic [9:0] dip);
    DIP = dip;
    @(negedge clk);
    enter = 1'b1;
    repeat (DB + 8) @(negedge clk);
    enter = 1'b0;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [9:0] key(input int d);
    logic [9:0] k;
    k = 10'd1;
    return k << d;
  endfunction

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({datain, valid, digit_tens, digit_ones, pending, err} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {datain, valid, digit_tens, digit_ones, pending, err});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0;
    press(key(4));
    n_cmp++;
    if (digit_tens !== 4'd4 || pending !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_tens: got tens=%0d pending=%b want tens=4 pending=1", digit_tens, pending);
    end
    v0 = v_cnt;
    press(key(7));
    n_cmp++;
    if (v_cnt - v0 != 1 || v_data !== 8'd47) begin
      n_bad++;
      $display("FAIL basic_valid: got %0d strobes data=%0d want 1 strobe data=47", v_cnt - v0, v_data);
    end
    n_cmp++;
    if (datain !== 8'd47 || digit_ones !== 4'd7 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_final: got datain=%0d ones=%0d pending=%b want 47 7 0", datain, digit_ones, pending);
    end
  endtask

  task automatic test_bounce();
    int v0, e0;
    v0 = v_cnt; e0 = e_cnt;
    DIP = key(9);
    for (int i = 0; i < 20; i++) begin
      enter = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    enter = 1'b1;
    repeat (10) @(negedge clk);
    enter = 1'b0;
    repeat (DB + 8) @(negedge clk);
    n_cmp++;
    if (digit_tens !== 4'd9 || pending !== 1'b1 || v_cnt != v0 || e_cnt != e0) begin
      n_bad++;
      $display("FAIL bounce: got tens=%0d pending=%b valids=%0d errs=%0d want 9 1 0 0",
               digit_tens, pending, v_cnt - v0, e_cnt - e0);
    end
    pulse_clear();
    n_cmp++;
    if (digit_tens !== 4'd0 || pending !== 1'b0 || datain !== 8'd47) begin
      n_bad++;
      $display("FAIL idle_clear: got tens=%0d pending=%b datain=%0d want 0 0 47", digit_tens, pending, datain);
    end
  endtask

  task automatic test_boundaries();
    int v0;
    logic [7:0] exp [3];
    int         t   [3];
    int         o   [3];
    exp = '{8'd99, 8'd0, 8'd5};
    t   = '{9, 0, 0};
    o   = '{9, 0, 5};
    for (int i = 0; i < 3; i++) begin
      v0 = v_cnt;
      press(key(t[i]));
      press(key(o[i]));
      n_cmp++;
      if (v_cnt - v0 != 1 || datain !== exp[i] || v_data !== exp[i]) begin
        n_bad++;
        $display("FAIL boundary_%0d%0d: got %0d strobes datain=%0d want 1 strobe datain=%0d",
                 t[i], o[i], v_cnt - v0, datain, exp[i]);
      end
    end
  endtask

  task automatic test_invalid();
    int v0, e0;
    e0 = e_cnt; v0 = v_cnt;
    press(10'd0);
    n_cmp++;
    if (e_cnt - e0 != 1 || pending !== 1'b0 || v_cnt != v0) begin
      n_bad++;
      $display("FAIL invalid_tens: got errs=%0d pending=%b want 1 err pending=0", e_cnt - e0, pending);
    end
    press(key(2));
    e0 = e_cnt;
    press(key(2) | key(3));
    n_cmp++;
    if (e_cnt - e0 != 1 || pending !== 1'b1 || datain !== 8'd5 || digit_tens !== 4'd2) begin
      n_bad++;
      $display("FAIL invalid_ones: got errs=%0d pending=%b datain=%0d tens=%0d want 1 1 5 2",
               e_cnt - e0, pending, datain, digit_tens);
    end
    press(key(1));
    n_cmp++;
    if (datain !== 8'd21) begin
      n_bad++;
      $display("FAIL invalid_recover: got %0d want 21", datain);
    end
  endtask

  task automatic test_clear();
    int v0;
    press(key(6));
    v0 = v_cnt;
    DIP = key(4);
    @(negedge clk);
    enter = 1'b1;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    repeat (DB + 4) @(negedge clk);
    enter = 1'b0;
    repeat (DB + 8) @(negedge clk);
    n_cmp++;
    if (v_cnt != v0 || pending !== 1'b0 || digit_tens !== 4'd0 ||
        digit_ones !== 4'd0 || datain !== 8'd21) begin
      n_bad++;
      $display("FAIL clear_drop: got valids=%0d pending=%b tens=%0d ones=%0d datain=%0d want 0 0 0 0 21",
               v_cnt - v0, pending, digit_tens, digit_ones, datain);
    end
    press(key(1));
    press(key(2));
    n_cmp++;
    if (datain !== 8'd12) begin
      n_bad++;
      $display("FAIL clear_followup: got %0d want 12", datain);
    end
  endtask

  task automatic test_async_reset();
    press(key(3));
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({datain, valid, digit_tens, digit_ones, pending, err} !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0",
               {datain, valid, digit_tens, digit_ones, pending, err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(key(8));
    press(key(1));
    n_cmp++;
    if (datain !== 8'd81) begin
      n_bad++;
      $display("FAIL async_followup: got %0d want 81", datain);
    end
  endtask

  task automatic test_random();
    logic [9:0] dip;
    int         m_tens, m_ones, m_data;
    bit         m_in_ones;
    int         exp_v, exp_e, v0, e0, d;
    m_tens = 0; m_ones = 0; m_data = 81; m_in_ones = 1'b0;
    pulse_clear();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        pulse_clear();
        m_tens = 0; m_ones = 0; m_in_ones = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) dip = 10'($urandom);
      else dip = key(int'($urandom_range(0, 9)));
      exp_v = 0; exp_e = 0;
      if ($countones(dip) != 1) begin
        exp_e = 1;
      end else begin
        d = 0;
        for (int k = 0; k < 10; k++) if (dip[k]) d = k;
        if (!m_in_ones) begin
          m_tens = d; m_ones = 0; m_in_ones = 1'b1;
        end else begin
          m_ones = d; m_data = m_tens * 10 + m_ones; m_in_ones = 1'b0; exp_v = 1;
        end
      end
      v0 = v_cnt; e0 = e_cnt;
      press(dip);
      n_cmp++;
      if (v_cnt - v0 != exp_v || e_cnt - e0 != exp_e ||
          int'(digit_tens) != m_tens || int'(digit_ones) != m_ones ||
          int'(datain) != m_data || pending !== m_in_ones ||
          (exp_v == 1 && int'(v_data) != m_data)) begin
        n_bad++;
        $display("FAIL random_%0d dip=%b: got v=%0d e=%0d t=%0d o=%0d d=%0d p=%b want v=%0d e=%0d t=%0d o=%0d d=%0d p=%b",
                 it, dip, v_cnt - v0, e_cnt - e0, digit_tens, digit_ones, datain, pending,
                 exp_v, exp_e, m_tens, m_ones, m_data, m_in_ones);
      end
    end
  endtask

  task automatic test_strobe_protocol();
    n_cmp++;
    if (vio_cnt != 0) begin
      n_bad++;
      $display("FAIL strobe_protocol: got %0d violations want 0", vio_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_boundaries();
    test_invalid();
    test_clear();
    test_async_reset();
    test_random();
    test_strobe_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
